// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block: FSM state encoding and the
// glitch-filter length used when PWM_CAPTURE_GLITCH_FILTER_EN is defined.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } pwm_state_e;

    // Number of consecutive samples a new level must hold before it is accepted.
    localparam int unsigned FILT_LEN = 3;
    // Width of the filter run-length counter (holds 0..FILT_LEN-1).
    localparam int unsigned FILT_CW  = 2;

endpackage : pwm_pkg

// File: rtl/pwm_sync.sv
// Input conditioning for pwm_capture: 2-flop synchronizer, optional glitch
// filter (macro PWM_CAPTURE_GLITCH_FILTER_EN) and single-cycle rise/fall events.
// Without the filter the edge events reach the FSM 3 clk edges after pwm_in
// changes; with it, 5 edges, and pulses shorter than FILT_LEN are dropped.
module pwm_sync
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_r;
    logic sync2_r;

    // Two-stage synchronizer for the asynchronous PWM input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pwm_in;
            sync2_r <= sync1_r;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN

    logic               level_r;
    logic [FILT_CW-1:0] filt_cnt_r;
    logic               differ_s;
    logic               commit_s;

    // A level change is committed on the cycle its FILT_LEN-th sample is seen,
    // so the edge event leaves this block in the same cycle the level flips.
    always_comb begin
        differ_s = (sync2_r != level_r);
        commit_s = differ_s && (filt_cnt_r == FILT_CW'(FILT_LEN - 1));
    end

    // Run-length counter of samples differing from the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r    <= 1'b0;
            filt_cnt_r <= {FILT_CW{1'b0}};
        end else if (commit_s) begin
            level_r    <= sync2_r;
            filt_cnt_r <= {FILT_CW{1'b0}};
        end else if (differ_s) begin
            filt_cnt_r <= filt_cnt_r + 2'd1;
        end else begin
            filt_cnt_r <= {FILT_CW{1'b0}};
        end
    end

    assign level_o = level_r;
    assign rise_o  = commit_s & sync2_r;
    assign fall_o  = commit_s & ~sync2_r;

`else

    logic prev_r;

    // Previous synchronized level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= sync2_r;
        end
    end

    assign level_o = sync2_r;
    assign rise_o  = sync2_r & ~prev_r;
    assign fall_o  = ~sync2_r & prev_r;

`endif

endmodule : pwm_sync

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of pwm_in in clk cycles and
// reports a timeout when no rising edge arrives within 2^CW-1 cycles.
// Optional glitch filter selected by macro PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic           pwm_in,
    output logic [WIDTH:0] high_o,
    output logic [WIDTH:0] period_o,
    output logic           valid_o,
    output logic           timeout_o,
    output logic           level_o
);

    localparam int CW = WIDTH + 1;
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic          rise_s;
    logic          fall_s;
    logic          level_s;

    pwm_state_e    state_r;
    logic [CW-1:0] high_cnt_r;
    logic [CW-1:0] per_cnt_r;
    logic [CW-1:0] high_r;
    logic [CW-1:0] period_r;
    logic          valid_r;
    logic          timeout_r;

    pwm_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_in  (pwm_in),
        .level_o (level_s),
        .rise_o  (rise_s),
        .fall_o  (fall_s)
    );

    // Measurement FSM with counters and registered result/pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            high_cnt_r <= CNT_ZERO;
            per_cnt_r  <= CNT_ZERO;
            high_r     <= CNT_ZERO;
            period_r   <= CNT_ZERO;
            valid_r    <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
            if (!enable) begin
                // Disable wins over any simultaneous edge; results hold.
                state_r    <= IDLE;
                high_cnt_r <= CNT_ZERO;
                per_cnt_r  <= CNT_ZERO;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= WAIT_RISE;
                    end
                    WAIT_RISE: begin
                        // Any pulse already in progress is ignored.
                        if (rise_s) begin
                            state_r    <= MEAS_HIGH;
                            high_cnt_r <= CNT_ONE;
                            per_cnt_r  <= CNT_ONE;
                        end
                    end
                    MEAS_HIGH: begin
                        if (per_cnt_r == CNT_MAX) begin
                            timeout_r  <= 1'b1;
                            state_r    <= WAIT_RISE;
                            high_cnt_r <= CNT_ZERO;
                            per_cnt_r  <= CNT_ZERO;
                        end else if (fall_s) begin
                            state_r   <= MEAS_LOW;
                            per_cnt_r <= per_cnt_r + CNT_ONE;
                        end else begin
                            high_cnt_r <= high_cnt_r + CNT_ONE;
                            per_cnt_r  <= per_cnt_r + CNT_ONE;
                        end
                    end
                    MEAS_LOW: begin
                        // A rise on the last countable cycle still completes the period.
                        if (rise_s) begin
                            high_r     <= high_cnt_r;
                            period_r   <= per_cnt_r;
                            valid_r    <= 1'b1;
                            state_r    <= MEAS_HIGH;
                            high_cnt_r <= CNT_ONE;
                            per_cnt_r  <= CNT_ONE;
                        end else if (per_cnt_r == CNT_MAX) begin
                            timeout_r  <= 1'b1;
                            state_r    <= WAIT_RISE;
                            high_cnt_r <= CNT_ZERO;
                            per_cnt_r  <= CNT_ZERO;
                        end else begin
                            per_cnt_r <= per_cnt_r + CNT_ONE;
                        end
                    end
                    default: begin
                        state_r    <= IDLE;
                        high_cnt_r <= CNT_ZERO;
                        per_cnt_r  <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

    assign high_o    = high_r;
    assign period_o  = period_r;
    assign valid_o   = valid_r;
    assign timeout_o = timeout_r;
    assign level_o   = level_s;

endmodule : pwm_capture

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: a scoreboard queue receives the expected
// (high, period) pair whenever a rise that completes a period is driven, and a
// negedge monitor pops and compares it when valid_o pulses.
module tb_pwm_capture;

    localparam int WIDTH = 8;
    localparam int CW    = WIDTH + 1;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          pwm_in;
    logic [CW-1:0] high_o;
    logic [CW-1:0] period_o;
    logic          valid_o;
    logic          timeout_o;
    logic          level_o;

    int errors = 0;
    int checks = 0;
    int to_seen = 0;

    logic [2*CW-1:0] sb_q[$];
    bit armed = 1'b0;
    int last_h = 0;
    int last_l = 0;
    int exp_high = 0;
    int exp_per = 0;

    pwm_capture #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .pwm_in    (pwm_in),
        .high_o    (high_o),
        .period_o  (period_o),
        .valid_o   (valid_o),
        .timeout_o (timeout_o),
        .level_o   (level_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // A rise while a measurement is running completes the previous period.
    task automatic push_last();
        if (armed) begin
            sb_q.push_back({CW'(last_h), CW'(last_h + last_l)});
            exp_high = last_h;
            exp_per  = last_h + last_l;
        end
        armed = 1'b1;
    endtask

    task automatic period(input int h, input int l);
        push_last();
        pwm_in = 1'b1;
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (l) @(negedge clk);
        last_h = h;
        last_l = l;
    endtask

    // Scoreboard monitor and timeout pulse counter.
    always @(negedge clk) begin : mon
        logic [2*CW-1:0] e;
        if (rst_n === 1'b1 && valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("valid_without_expect", {31'd0, valid_o}, 0);
            end else begin
                e = sb_q.pop_front();
                chk("high_o", high_o, int'(e[2*CW-1:CW]));
                chk("period_o", period_o, int'(e[CW-1:0]));
            end
        end
        if (timeout_o === 1'b1) to_seen++;
    end

    initial begin
        int got_lat;
        rst_n  = 1'b0;
        enable = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_high", high_o, 0);
        chk("rst_period", period_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_level", level_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        repeat (4) @(negedge clk);

        // 25% duty at full resolution
        repeat (5) period(64, 192);

`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
        // Fastest possible toggle
        repeat (6) period(1, 1);
`endif

        // Constant high after one rise -> timeout, results held
        push_last();
        pwm_in = 1'b1;
        got_lat = 0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (timeout_o === 1'b1) begin
                got_lat = k;
                break;
            end
        end
        chk("timeout_latency", got_lat, LAT + 511);
        chk("timeout_high_hold", high_o, exp_high);
        chk("timeout_period_hold", period_o, exp_per);
        chk("level_high", level_o, 1);
        armed = 1'b0;
        @(negedge clk);
        chk("timeout_one_cycle", timeout_o, 0);
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);

        // Enable dropped in the low phase
        period(10, 20);
        period(10, 20);
        push_last();
        pwm_in = 1'b1;
        repeat (10) @(negedge clk);
        pwm_in = 1'b0;
        repeat (8) @(negedge clk);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        chk("disable_high_hold", high_o, 10);
        chk("disable_period_hold", period_o, 30);
        enable = 1'b1;
        repeat (8) @(negedge clk);
        armed = 1'b0;
        repeat (3) period(10, 20);

        // 2-cycle glitch inside the low phase of a 100/156 wave
        period(100, 156);
        push_last();
        pwm_in = 1'b1;
        repeat (100) @(negedge clk);
        pwm_in = 1'b0;
        repeat (50) @(negedge clk);
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
        sb_q.push_back({CW'(100), CW'(150)});
`endif
        pwm_in = 1'b1;
        repeat (2) @(negedge clk);
        pwm_in = 1'b0;
        repeat (104) @(negedge clk);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        last_h = 100;
        last_l = 156;
`else
        last_h = 2;
        last_l = 104;
`endif
        repeat (2) period(100, 156);

        // Reset in the middle of a high phase
        push_last();
        pwm_in = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_high", high_o, 0);
        chk("mid_rst_period", period_o, 0);
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_timeout", timeout_o, 0);
        chk("mid_rst_level", level_o, 0);
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        armed = 1'b0;
        repeat (3) @(negedge clk);
        repeat (3) period(40, 60);
        push_last();
        pwm_in = 1'b1;
        repeat (10) @(negedge clk);
        pwm_in = 1'b0;
        repeat (30) @(negedge clk);

        chk("sb_drain", sb_q.size(), 0);
        chk("timeout_count", to_seen, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pwm_capture
